play_controller: RTL and testbench
==================================

PLAY_CONTROLLER -- requirements
Module: play_controller

Interface
REQ-001 Parameter: STEPS, 16, number of steps per pattern pass.
REQ-002 Parameter: TICK_NUM, 750_000_000, phase-accumulator modulus (50 MHz x 60 / 4 gives one step per 16th note); range 1024..2^30-1024.
REQ-003 Clock and reset SHALL be: reset nReset, asynchronous, active-low; clock CLOCK_50.
REQ-004 CLOCK_50  input  1  system clock, 50 MHz.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 Start  input  1  single-cycle play request from the input interface.
REQ-007 Stop  input  1  single-cycle abort request.
REQ-008 BPM  input  10  tempo in beats per minute; sampled only on an accepted Start.
REQ-009 Loops  input  7  pattern pass count; 0 means repeat until Stop; sampled only on an accepted Start.
REQ-010 play_en  output  1  high for exactly the duration of playback; feeds the input interface.
REQ-011 step  output  4  current step index, 0..STEPS-1.
REQ-012 step_tick  output  1  one-cycle pulse on the first cycle of every step.
REQ-013 loop_count  output  7  completed passes in the current playback.
REQ-014 loop_done  output  1  one-cycle pulse when a pass wraps from step STEPS-1.

Function
REQ-015 The FSM SHALL have two states: IDLE (play_en=0) and RUN (play_en=1).
REQ-016 In IDLE, Start=1 with BPM!=0 and Stop=0 SHALL be accepted: BPM and Loops latched, accumulator cleared, step=0, loop_count=0, state RUN on the next edge.
REQ-017 Start with BPM==0, or Start and Stop in the same cycle, SHALL be ignored (remain IDLE).
REQ-018 step_tick SHALL assert on the first RUN cycle (step 0) with 1-cycle latency from accepted Start.
REQ-019 Each RUN cycle: sum = acc + BPM_latched (30-bit); if sum >= TICK_NUM then acc <= sum - TICK_NUM and the step advances, else acc <= sum.
REQ-020 Step period SHALL be TICK_NUM/BPM cycles on average, with no cumulative drift.
REQ-021 On an advance from step<STEPS-1, step SHALL increment and step_tick SHALL pulse with the new step value.
REQ-022 On an advance from STEPS-1: loop_done pulses and loop_count increments (saturating at 127); if Loops_latched!=0 and the new count equals Loops_latched, state goes IDLE with no step_tick; otherwise step wraps to 0 and step_tick pulses.
REQ-023 Stop in RUN SHALL go IDLE on the next edge; Stop takes precedence over a simultaneous advance, so no step_tick or loop_done is issued.
REQ-024 Start in RUN SHALL be ignored; BPM and Loops changes during RUN SHALL have no effect.
REQ-025 On return to IDLE: step=0, acc=0; loop_count holds its final value until the next accepted Start.
REQ-026 step_tick and loop_done SHALL never assert in IDLE.

Reset
REQ-027 nReset low SHALL asynchronously force IDLE, play_en=0, step=0, step_tick=0, loop_count=0, loop_done=0, acc=0, latched BPM and Loops = 0, including mid-playback.
REQ-028 After nReset release, the first accepted Start SHALL behave exactly as in REQ-016.

Structure
REQ-029 A shared package SHALL hold STEPS, the default TICK_NUM, the accumulator width (30) and the FSM state encoding.
REQ-030 The phase accumulator SHALL be a sub-module, step_tick_gen: inputs clear, enable and BPM; output advance pulse.
REQ-031 All outputs SHALL be registered.

Verification (TICK_NUM=100)
REQ-032 BPM=25, Loops=2, Start pulse -> play_en high 1 cycle later for 128 cycles; step_tick every 4 cycles; loop_done twice; final loop_count=2.
REQ-033 BPM=0, Start pulse -> play_en stays 0; no step_tick.
REQ-034 BPM=30, Loops=0 -> step intervals follow the 4,3,3 cycle pattern (avg 3.33); runs past 3 passes; Stop -> play_en=0 next cycle, step=0.
REQ-035 BPM=25, Loops=1, Stop asserted on the same cycle as the step-15 advance -> no loop_done; play_en falls; loop_count=0.
REQ-036 nReset pulsed at step 7 of a run -> all outputs 0 immediately; next Start with BPM=50 -> step_tick every 2 cycles from step 0.
REQ-037 In RUN, change BPM/Loops and pulse Start -> timing and length are unchanged.

Source files
------------

// File: rtl/play_controller_pkg.sv
// Shared constants, FSM encoding and helpers for the pattern play controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package play_controller_pkg;

  localparam int STEPS            = 16;
  localparam int STEP_W           = $clog2(STEPS);
  localparam int TICK_NUM_DEFAULT = 750_000_000;  // 50 MHz * 60 / 4 -> one step per 16th note
  localparam int ACC_W            = 30;
  localparam int BPM_W            = 10;
  localparam int LOOPS_W          = 7;

  localparam logic [LOOPS_W-1:0] LOOP_MAX = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Pass counter increment that sticks at the top value instead of wrapping.
  function automatic logic [LOOPS_W-1:0] sat_inc(input logic [LOOPS_W-1:0] v);
    return (v == LOOP_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/play_controller_if.sv
// Control/status bundle between the input interface and the play controller.
// Latency: n/a (wires only).
// Backpressure: none; Start/Stop are single-cycle requests, status is level/pulse.
// Ports: Start, Stop, BPM, Loops (requests); play_en, step, step_tick,
//        loop_count, loop_done (status).
interface play_controller_if;
  import play_controller_pkg::*;

  logic               Start;
  logic               Stop;
  logic [BPM_W-1:0]   BPM;
  logic [LOOPS_W-1:0] Loops;
  logic               play_en;
  logic [STEP_W-1:0]  step;
  logic               step_tick;
  logic [LOOPS_W-1:0] loop_count;
  logic               loop_done;

  // master: the requester (input interface / bench); slave: the controller.
  modport master (
    output Start, Stop, BPM, Loops,
    input  play_en, step, step_tick, loop_count, loop_done
  );

  modport slave (
    input  Start, Stop, BPM, Loops,
    output play_en, step, step_tick, loop_count, loop_done
  );

endinterface

// File: rtl/play_controller_step_tick_gen.sv
// Phase accumulator: adds BPM every enabled cycle and flags an advance on each TICK_NUM crossing.
// Latency: advance is combinational from the accumulator register and current inputs.
// Backpressure: none; clear has priority over enable.
// Ports: CLOCK_50, nReset, clear, enable, bpm -> advance.
module step_tick_gen
  import play_controller_pkg::*;
#(
  parameter int TICK_NUM = TICK_NUM_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             nReset,
  input  logic             clear,
  input  logic             enable,
  input  logic [BPM_W-1:0] bpm,
  output logic             advance
);

  localparam logic [ACC_W-1:0] TICK = ACC_W'(TICK_NUM);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;

  // The remainder is carried over on each crossing, so the average step period
  // is exactly TICK_NUM/bpm with no cumulative drift. acc < TICK and bpm < 2^10
  // keep sum below 2^30.
  always_comb begin
    sum     = acc_q + {{(ACC_W-BPM_W){1'b0}}, bpm};
    advance = enable && (sum >= TICK);
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = advance ? (sum - TICK) : sum;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/play_controller.sv
// Pattern play controller: steps through STEPS steps at BPM tempo for Loops passes (0 = until Stop).
// Latency: accepted Start -> play_en/step_tick one cycle later; all outputs registered.
// Backpressure: none; Start is ignored while running or with BPM==0, Stop wins over everything.
// Ports: CLOCK_50, nReset, bus (slave: Start/Stop/BPM/Loops in, play status out).
module play_controller
  import play_controller_pkg::*;
#(
  parameter int TICK_NUM = TICK_NUM_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  play_controller_if.slave  bus
);

  state_t             state_q, state_d;
  logic [BPM_W-1:0]   bpm_q, bpm_d;
  logic [LOOPS_W-1:0] loops_q, loops_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               step_tick_q, step_tick_d;
  logic [LOOPS_W-1:0] loop_count_q, loop_count_d;
  logic               loop_done_q, loop_done_d;

  logic               acc_clear;
  logic               acc_enable;
  logic               advance;
  logic [LOOPS_W-1:0] next_count;

  step_tick_gen #(
    .TICK_NUM (TICK_NUM)
  ) u_step_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .nReset   (nReset),
    .clear    (acc_clear),
    .enable   (acc_enable),
    .bpm      (bpm_q),
    .advance  (advance)
  );

  always_comb begin
    state_d      = state_q;
    bpm_d        = bpm_q;
    loops_d      = loops_q;
    step_d       = step_q;
    loop_count_d = loop_count_q;
    step_tick_d  = 1'b0;
    loop_done_d  = 1'b0;
    acc_clear    = 1'b1;
    acc_enable   = (state_q == ST_RUN);
    next_count   = sat_inc(loop_count_q);

    unique case (state_q)
      ST_IDLE: begin
        // Accumulator is held at zero while idle, so it starts clean on RUN entry.
        if (bus.Start && !bus.Stop && (bus.BPM != '0)) begin
          state_d      = ST_RUN;
          bpm_d        = bus.BPM;
          loops_d      = bus.Loops;
          step_d       = '0;
          loop_count_d = '0;
          step_tick_d  = 1'b1;
        end
      end

      ST_RUN: begin
        acc_clear = 1'b0;
        if (bus.Stop) begin
          // Abort suppresses any advance computed in the same cycle.
          state_d   = ST_IDLE;
          step_d    = '0;
          acc_clear = 1'b1;
        end else if (advance) begin
          if (step_q != STEP_W'(STEPS-1)) begin
            step_d      = step_q + 1'b1;
            step_tick_d = 1'b1;
          end else begin
            loop_done_d  = 1'b1;
            loop_count_d = next_count;
            step_d       = '0;
            if ((loops_q != '0) && (next_count == loops_q)) begin
              // Last pass finished: drop out without announcing a new step 0.
              state_d   = ST_IDLE;
              acc_clear = 1'b1;
            end else begin
              step_tick_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q      <= ST_IDLE;
      bpm_q        <= '0;
      loops_q      <= '0;
      step_q       <= '0;
      step_tick_q  <= 1'b0;
      loop_count_q <= '0;
      loop_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bpm_q        <= bpm_d;
      loops_q      <= loops_d;
      step_q       <= step_d;
      step_tick_q  <= step_tick_d;
      loop_count_q <= loop_count_d;
      loop_done_q  <= loop_done_d;
    end
  end

  assign bus.play_en    = (state_q == ST_RUN);
  assign bus.step       = step_q;
  assign bus.step_tick  = step_tick_q;
  assign bus.loop_count = loop_count_q;
  assign bus.loop_done  = loop_done_q;

endmodule

// File: tb/tb_play_controller.sv
// Self-checking bench for play_controller with TICK_NUM=100.
// Expected outputs come from closed-form step arithmetic: after k RUN cycles,
// floor((k-1)*BPM/TICK) steps have been announced.
module tb_play_controller;

  localparam int T     = 100;
  localparam int NSTEP = 16;

  logic clk = 1'b0;
  logic nReset;

  always #5 clk = ~clk;

  play_controller_if bus();

  play_controller #(
    .TICK_NUM (T)
  ) dut (
    .CLOCK_50 (clk),
    .nReset   (nReset),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state carried between plays.
  bit run_m     = 1'b0;
  bit stop_pend = 1'b0;
  int lc_hold   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ctx, input int pe, input int st, input int tk,
                           input int lc, input int ld);
    check($sformatf("%s play_en", ctx),    32'(bus.play_en),    32'(pe));
    check($sformatf("%s step", ctx),       32'(bus.step),       32'(st));
    check($sformatf("%s step_tick", ctx),  32'(bus.step_tick),  32'(tk));
    check($sformatf("%s loop_count", ctx), 32'(bus.loop_count), 32'(lc));
    check($sformatf("%s loop_done", ctx),  32'(bus.loop_done),  32'(ld));
  endtask

  // Called at a negedge. Pulses Start with (B,L), then checks ncyc cycles.
  // ks: RUN cycle in which Stop is asserted (0 = none); rk: cycle of a reset pulse (0 = none).
  // While running, BPM/Loops are scrambled and Start is randomly re-pulsed.
  task automatic run_play(input int B, input int L, input int ks, input int ncyc,
                          input int rk, output int pe_cnt, output int ld_cnt);
    int n, np, lc;
    int e_pe, e_st, e_tk, e_lc, e_ld;
    pe_cnt    = 0;
    ld_cnt    = 0;
    bus.Start = 1'b1;
    bus.Stop  = 1'b0;
    bus.BPM   = 10'(B);
    bus.Loops = 7'(L);
    stop_pend = 1'b0;
    if (B != 0) begin
      run_m   = 1'b1;
      lc_hold = 0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      bus.Stop  = 1'b0;
      n  = (B != 0) ? ((k - 1) * B / T) : 0;
      np = (k >= 2 && B != 0) ? ((k - 2) * B / T) : -1;
      lc = (n / NSTEP > 127) ? 127 : n / NSTEP;
      if (stop_pend) begin
        run_m     = 1'b0;
        stop_pend = 1'b0;
      end
      if (run_m && L != 0 && n >= L * NSTEP) begin
        run_m   = 1'b0;
        lc_hold = L;
        e_pe = 0; e_st = 0; e_tk = 0; e_lc = L; e_ld = 1;
      end else if (run_m) begin
        e_pe = 1;
        e_st = n % NSTEP;
        e_tk = (k == 1 || n != np) ? 1 : 0;
        e_ld = (k > 1 && (n / NSTEP) != (np / NSTEP)) ? 1 : 0;
        e_lc = lc;
      end else begin
        e_pe = 0; e_st = 0; e_tk = 0; e_lc = lc_hold; e_ld = 0;
      end
      check_all($sformatf("bpm%0d loops%0d k%0d", B, L, k), e_pe, e_st, e_tk, e_lc, e_ld);
      pe_cnt += int'(bus.play_en);
      ld_cnt += int'(bus.loop_done);

      if (k == rk) begin
        nReset = 1'b0;
        #1;
        check_all($sformatf("async reset k%0d", k), 0, 0, 0, 0, 0);
        run_m   = 1'b0;
        lc_hold = 0;
        #2;
        nReset = 1'b1;
      end else if (e_pe == 1) begin
        if (k == ks) begin
          bus.Stop  = 1'b1;
          stop_pend = 1'b1;
          lc_hold   = e_lc;
        end
        bus.Start = ($urandom_range(0, 3) == 0);
        bus.BPM   = 10'($urandom);
        bus.Loops = 7'($urandom);
      end
    end
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
  endtask

  initial begin
    int pe, ld;
    int B, L, ks, fin, ncyc;

    nReset    = 1'b0;
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    bus.BPM   = '0;
    bus.Loops = '0;
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    check_all("post reset", 0, 0, 0, 0, 0);

    // Two passes at one step per 4 cycles.
    run_play(25, 2, 0, 132, 0, pe, ld);
    check("bpm25 play_en cycles", 32'(pe), 32'd128);
    check("bpm25 loop_done count", 32'(ld), 32'd2);

    // BPM of zero never starts.
    run_play(0, 1, 0, 10, 0, pe, ld);
    check("bpm0 play_en cycles", 32'(pe), 32'd0);

    // Start and Stop together in IDLE is ignored.
    bus.Start = 1'b1;
    bus.Stop  = 1'b1;
    bus.BPM   = 10'd40;
    bus.Loops = 7'd1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      bus.Stop  = 1'b0;
      check_all($sformatf("start+stop k%0d", k), 0, 0, 0, lc_hold, 0);
    end

    // Fractional period (4,3,3 pattern), endless, aborted after >3 passes.
    run_play(30, 0, 200, 205, 0, pe, ld);
    check("bpm30 loop_done count", 32'(ld), 32'd3);

    // Stop coincides with the step-15 advance of the only pass.
    run_play(25, 1, 64, 68, 0, pe, ld);
    check("stop@wrap loop_done count", 32'(ld), 32'd0);

    // Reset in the middle of step 7, then a fresh fast play.
    run_play(25, 3, 0, 32, 29, pe, ld);
    run_play(50, 1, 0, 36, 0, pe, ld);
    check("bpm50 play_en cycles", 32'(pe), 32'd32);

    // Randomized plays.
    for (int i = 0; i < 8; i++) begin
      B   = $urandom_range(10, 99);
      L   = $urandom_range(0, 3);
      ks  = (L == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(2, 250) : 0;
      fin = (L * NSTEP * T + B - 1) / B + 1;
      ncyc = (ks != 0 && (L == 0 || ks < fin)) ? ks + 4 : fin + 4;
      run_play(B, L, ks, ncyc, 0, pe, ld);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
